alu_exec_ctrl: RTL and testbench

//  Issue/writeback sequencer directly upstream and downstream of the 8-bit ALU.
//  - Accepts one register-to-register instruction on a valid/ready handshake.
//  - Reads two source registers from an internal 8x8 register file and drives the
//    ALU operands and select code; holds them stable while the ALU settles.
//  - Writes the ALU result back to the destination register and latches the
//    7-bit status flags.

---
 rtl/alu_exec_ctrl_pkg.sv | 68 ++++++
 rtl/alu_exec_ctrl_reg_file.sv | 36 +++
 rtl/alu_exec_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_exec_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: opcodes, flag
// bit positions, FSM encoding and small decode helpers.
package alu_exec_ctrl_pkg;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h04;
  localparam logic [7:0] OP_INC  = 8'h05;
  localparam logic [7:0] OP_DEC  = 8'h06;
  localparam logic [7:0] OP_MOD  = 8'h07;
  localparam logic [7:0] OP_NOT  = 8'h08;
  localparam logic [7:0] OP_NEG  = 8'h09;
  localparam logic [7:0] OP_AND  = 8'h0A;
  localparam logic [7:0] OP_OR   = 8'h0B;
  localparam logic [7:0] OP_XOR  = 8'h0D;
  localparam logic [7:0] OP_SHL  = 8'h0E;
  localparam logic [7:0] OP_NAND = 8'h0F;
  localparam logic [7:0] OP_NOR  = 8'h10;
  localparam logic [7:0] OP_XNOR = 8'h11;
  localparam logic [7:0] OP_ROL  = 8'h12;
  localparam logic [7:0] OP_ROR  = 8'h13;

  localparam int FLAG_Z  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_S  = 2;
  localparam int FLAG_P  = 3;
  localparam int FLAG_I  = 4;
  localparam int FLAG_D  = 5;
  localparam int FLAG_OV = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  function automatic logic op_is_legal(input logic [7:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_INC, OP_DEC, OP_MOD, OP_NOT, OP_NEG,
      OP_AND, OP_OR, OP_XOR, OP_SHL, OP_NAND, OP_NOR, OP_XNOR, OP_ROL,
      OP_ROR:  legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic op_is_div(input logic [7:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // C, I, D come straight from the ALU; Z/S/P always follow the captured result.
  function automatic logic [6:0] wb_flags(input logic [6:0] alu_f,
                                          input logic [7:0] res,
                                          input logic       div_zero);
    logic [6:0] f;
    f          = alu_f;
    f[FLAG_Z]  = (res == 8'h00);
    f[FLAG_S]  = res[7];
    f[FLAG_P]  = ~^res;
    f[FLAG_OV] = alu_f[FLAG_OV] | div_zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_reg_file.sv
// Register file: two combinational source read ports, one debug read port,
// one synchronous write port, cleared synchronously on rst.
module alu_exec_ctrl_reg_file #(
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr1,
  output logic [7:0]    rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [7:0]    rdata2,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  logic [7:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = mem[raddr1];
  assign rdata2   = mem[raddr2];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Issue/writeback sequencer around the 8-bit ALU: reads sources, holds ALU
// inputs while it settles, writes the result back and latches status flags.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready for an instruction; operands/sel latched on handshake
// ST_EXEC   | ALU inputs held; first capture of result and flags
// ST_SETTLE | inputs held for SETTLE_CYC cycles; recapture every cycle
// ST_WB     | write result/flags (unless illegal or div-by-zero), pulse done
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int NREGS      = 8,
  parameter int SETTLE_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [7:0]               instr_op,
  input  logic [$clog2(NREGS)-1:0] instr_rd,
  input  logic [$clog2(NREGS)-1:0] instr_rs1,
  input  logic [$clog2(NREGS)-1:0] instr_rs2,
  output logic [7:0]               alu_operand1,
  output logic [7:0]               alu_operand2,
  output logic [7:0]               alu_sel,
  input  logic [7:0]               alu_result,
  input  logic [6:0]               alu_flags,
  output logic [6:0]               flags_q,
  output logic                     done,
  output logic                     err_op,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [7:0]               dbg_data
);

  localparam int AW = $clog2(NREGS);
  localparam logic [2:0] SETTLE_INIT = 3'(SETTLE_CYC - 1);

  state_t        state;
  logic [2:0]    settle_cnt;
  logic [AW-1:0] rd_q;
  logic [7:0]    op_q;
  logic [7:0]    res_q;
  logic [6:0]    flg_q;

  logic          op_legal;
  logic          div_zero;
  logic          rf_we;
  logic [7:0]    rf_rdata1;
  logic [7:0]    rf_rdata2;

  // The divisor is still on alu_operand2 during WB, so div-by-zero is decided there.
  always_comb begin
    op_legal = op_is_legal(op_q);
    div_zero = op_is_div(op_q) && (alu_operand2 == 8'h00);
    rf_we    = (state == ST_WB) && op_legal && !div_zero;
  end

  alu_exec_ctrl_reg_file #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (res_q),
    .raddr1   (instr_rs1),
    .rdata1   (rf_rdata1),
    .raddr2   (instr_rs2),
    .rdata2   (rf_rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      settle_cnt   <= 3'd0;
      rd_q         <= '0;
      op_q         <= 8'h00;
      res_q        <= 8'h00;
      flg_q        <= 7'h00;
      alu_operand1 <= 8'h00;
      alu_operand2 <= 8'h00;
      alu_sel      <= 8'h00;
      flags_q      <= 7'h00;
      instr_ready  <= 1'b1;
      done         <= 1'b0;
      err_op       <= 1'b0;
    end else begin
      done   <= 1'b0;
      err_op <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            op_q         <= instr_op;
            rd_q         <= instr_rd;
            alu_operand1 <= rf_rdata1;
            alu_operand2 <= rf_rdata2;
            alu_sel      <= instr_op;
            instr_ready  <= 1'b0;
            state        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q      <= alu_result;
          flg_q      <= alu_flags;
          settle_cnt <= SETTLE_INIT;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          res_q <= alu_result;
          flg_q <= alu_flags;
          if (settle_cnt == 3'd0) begin
            state <= ST_WB;
          end else begin
            settle_cnt <= settle_cnt - 3'd1;
          end
        end
        ST_WB: begin
          if (op_legal) begin
            flags_q <= wb_flags(flg_q, res_q, div_zero);
          end else begin
            err_op <= 1'b1;
          end
          done        <= 1'b1;
          alu_sel     <= 8'h00;
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl with a behavioural ALU; checks a vector table,
// hand-written sequences and random instructions against a reference model.
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_op;
  logic [2:0] instr_rd, instr_rs1, instr_rs2;
  logic [7:0] alu_operand1, alu_operand2, alu_sel, alu_result;
  logic [6:0] alu_flags, flags_q;
  logic       done, err_op;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mr [8];
  logic [6:0] mflags;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.NREGS(8), .SETTLE_CYC(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_rd     (instr_rd),
    .instr_rs1    (instr_rs1),
    .instr_rs2    (instr_rs2),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_sel      (alu_sel),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .flags_q      (flags_q),
    .done         (done),
    .err_op       (err_op),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // ALU behaviour: {flags, result}. Z/S/P left at 0 here on purpose, so the
  // controller's own recomputation is what gets observed. I=a[0], D=b[0].
  function automatic logic [14:0] ref_alu(input logic [7:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic        c, ov, legal;
    r = 8'h00; c = 1'b0; ov = 1'b0; legal = 1'b1;
    case (op)
      8'h01: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                   ov = (a[7] == b[7]) && (r[7] != a[7]); end
      8'h02: begin r = a - b; c = (a < b); ov = (a[7] != b[7]) && (r[7] != a[7]); end
      8'h03: begin p = 16'(a) * 16'(b); r = p[7:0]; c = (p > 16'd255); end
      8'h04: r = (b == 8'h00) ? 8'h00 : a / b;
      8'h05: begin r = a + 8'd1; c = (a == 8'hFF); end
      8'h06: begin r = a - 8'd1; c = (a == 8'h00); end
      8'h07: r = (b == 8'h00) ? 8'h00 : a % b;
      8'h08: r = ~a;
      8'h09: r = 8'h00 - a;
      8'h0A: r = a & b;
      8'h0B: r = a | b;
      8'h0D: r = a ^ b;
      8'h0E: begin r = {a[6:0], 1'b0}; c = a[7]; end
      8'h0F: r = ~(a & b);
      8'h10: r = ~(a | b);
      8'h11: r = ~(a ^ b);
      8'h12: begin r = {a[6:0], a[7]}; c = a[7]; end
      8'h13: begin r = {a[0], a[7:1]}; c = a[0]; end
      default: legal = 1'b0;
    endcase
    if (!legal) return 15'h0000;
    return {ov, b[0], a[0], 1'b0, 1'b0, c, 1'b0, r};
  endfunction

  always_comb {alu_flags, alu_result} = ref_alu(alu_sel, alu_operand1, alu_operand2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural effect of one instruction, from the rules, not the FSM.
  task automatic model_apply(input logic [7:0] op, input int rd, input int rs1,
                             input int rs2, output logic err);
    logic [7:0] a, b, r;
    logic [6:0] f;
    a = mr[rs1];
    b = mr[rs2];
    {f, r} = ref_alu(op, a, b);
    err = !(op >= 8'h01 && op <= 8'h13 && op != 8'h0C);
    if (!err) begin
      f[0] = (r == 8'h00);
      f[2] = (r >= 8'd128);
      f[3] = ($countones(r) % 2 == 0);
      if ((op == 8'h04 || op == 8'h07) && b == 8'h00) f[6] = 1'b1;
      else mr[rd] = r;
      mflags = f;
    end
  endtask

  task automatic read_reg(input int a, output logic [7:0] d);
    dbg_addr = 3'(a);
    #1;
    d = dbg_data;
  endtask

  task automatic check_all_regs(input string name);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      read_reg(i, d);
      check(name, 32'(d), 32'(mr[i]));
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 20);
  endtask

  task automatic exec(input logic [7:0] op, input int rd, input int rs1, input int rs2,
                      output logic got_err);
    int guard, lat;
    logic exp_err;
    logic [7:0] d;
    @(negedge clk);
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", 32'(guard < 20), 32'd1);
    instr_valid = 1'b1; instr_op = op;
    instr_rd = 3'(rd); instr_rs1 = 3'(rs1); instr_rs2 = 3'(rs2);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wait_done(lat);
    got_err = err_op;
    check("done_latency", 32'(lat), 32'd3);
    model_apply(op, rd, rs1, rs2, exp_err);
    check("err_op", 32'(got_err), 32'(exp_err));
    check("flags_q", 32'(flags_q), 32'(mflags));
    read_reg(rd, d);
    check("reg_wb", 32'(d), 32'(mr[rd]));
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic preload(input int r, input logic [7:0] val);
    logic e, started;
    started = 1'b0;
    exec(8'h02, r, r, r, e);
    for (int b = 7; b >= 0; b--) begin
      if (started) exec(8'h01, r, r, r, e);
      if (val[b]) begin
        exec(8'h05, r, r, r, e);
        started = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [7:0] v1, v2, op;
    logic [2:0] rd;
    logic [7:0] exp_res;
    logic [6:0] exp_flags;
    logic       exp_err, exp_wr;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       e, rdy;
    logic [7:0] d;
    int         acc, dn, gap, lat;

    vecs[0]  = '{8'h7F, 8'h01, 8'h01, 3'd3, 8'h80, 7'h74, 1'b0, 1'b1};
    vecs[1]  = '{8'h05, 8'h05, 8'h02, 3'd4, 8'h00, 7'h39, 1'b0, 1'b1};
    vecs[2]  = '{8'h09, 8'h00, 8'h04, 3'd5, 8'h00, 7'h59, 1'b0, 1'b0};
    vecs[3]  = '{8'h09, 8'h00, 8'h07, 3'd5, 8'h00, 7'h59, 1'b0, 1'b0};
    vecs[4]  = '{8'h12, 8'h34, 8'h0C, 3'd6, 8'h00, 7'h00, 1'b1, 1'b0};
    vecs[5]  = '{8'h81, 8'h00, 8'h12, 3'd3, 8'h03, 7'h1A, 1'b0, 1'b1};
    vecs[6]  = '{8'h64, 8'h07, 8'h04, 3'd6, 8'h0E, 7'h20, 1'b0, 1'b1};
    vecs[7]  = '{8'h64, 8'h07, 8'h07, 3'd6, 8'h02, 7'h20, 1'b0, 1'b1};
    vecs[8]  = '{8'h10, 8'h10, 8'h03, 3'd7, 8'h00, 7'h0B, 1'b0, 1'b1};
    vecs[9]  = '{8'h03, 8'h05, 8'h02, 3'd3, 8'hFE, 7'h36, 1'b0, 1'b1};
    vecs[10] = '{8'h11, 8'h22, 8'h14, 3'd4, 8'h00, 7'h00, 1'b1, 1'b0};
    vecs[11] = '{8'h11, 8'h22, 8'h00, 3'd4, 8'h00, 7'h00, 1'b1, 1'b0};
    vecs[12] = '{8'hAA, 8'h55, 8'h0D, 3'd5, 8'hFF, 7'h2C, 1'b0, 1'b1};
    vecs[13] = '{8'hFF, 8'h01, 8'h01, 3'd6, 8'h00, 7'h3B, 1'b0, 1'b1};
    vecs[14] = '{8'h01, 8'h02, 8'h09, 3'd7, 8'hFF, 7'h1C, 1'b0, 1'b1};
    vecs[15] = '{8'h01, 8'h00, 8'h13, 3'd3, 8'h80, 7'h16, 1'b0, 1'b1};

    for (int i = 0; i < 8; i++) mr[i] = 8'h00;
    mflags = 7'h00;
    rst = 1'b1; instr_valid = 1'b0; instr_op = 8'h00;
    instr_rd = 3'd0; instr_rs1 = 3'd0; instr_rs2 = 3'd0; dbg_addr = 3'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_op), 32'd0);
    check("rst_sel", 32'(alu_sel), 32'd0);
    check("rst_op1", 32'(alu_operand1), 32'd0);
    check("rst_op2", 32'(alu_operand2), 32'd0);
    check("rst_flags", 32'(flags_q), 32'd0);
    check_all_regs("rst_regs");
    @(negedge clk) rst = 1'b0;

    // Vector table: R1/R2 preloaded, op rd,R1,R2
    for (int i = 0; i < NV; i++) begin
      preload(1, vecs[i].v1);
      preload(2, vecs[i].v2);
      exec(vecs[i].op, int'(vecs[i].rd), 1, 2, e);
      check("vec_err", 32'(e), 32'(vecs[i].exp_err));
      if (!vecs[i].exp_err) check("vec_flags", 32'(flags_q), 32'(vecs[i].exp_flags));
      if (vecs[i].exp_wr) begin
        read_reg(int'(vecs[i].rd), d);
        check("vec_res", 32'(d), 32'(vecs[i].exp_res));
      end
      check_all_regs("vec_regs");
    end

    // Back-to-back dependent pair: SUB R4 then AND reading R4
    preload(1, 8'h05);
    preload(2, 8'h05);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 8'h02; instr_rd = 3'd4; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
    @(posedge clk); #1;
    instr_op = 8'h0A; instr_rd = 3'd7; instr_rs1 = 3'd4; instr_rs2 = 3'd1;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!instr_ready && gap < 20);
    check("dep_issue_gap", 32'(gap), 32'd4);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wait_done(lat);
    check("dep_latency", 32'(lat), 32'd3);
    model_apply(8'h02, 4, 1, 2, e);
    model_apply(8'h0A, 7, 4, 1, e);
    read_reg(7, d);
    check("dep_r7", 32'(d), 32'h00);
    check("dep_flags", 32'(flags_q), 32'(mflags));
    check_all_regs("dep_regs");

    // instr_valid held across busy cycles: one accept per IDLE visit
    preload(1, 8'h01);
    preload(6, 8'h10);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 8'h01; instr_rd = 3'd6; instr_rs1 = 3'd6; instr_rs2 = 3'd1;
    acc = 0; dn = 0;
    for (int k = 0; k < 12; k++) begin
      rdy = instr_ready;
      @(posedge clk); #1;
      if (rdy) acc++;
      if (done) dn++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("hold_accepts", 32'(acc), 32'd3);
    check("hold_dones", 32'(dn), 32'd3);
    repeat (3) model_apply(8'h01, 6, 6, 1, e);
    read_reg(6, d);
    check("hold_r6", 32'(d), 32'h13);
    check("hold_flags", 32'(flags_q), 32'(mflags));
    check_all_regs("hold_regs");

    // Random instructions against the model
    for (int i = 1; i < 8; i++) preload(i, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      exec(8'($urandom_range(0, 21)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), e);
    end
    check_all_regs("rand_regs");

    // Reset while in SETTLE
    preload(1, 8'h7F);
    preload(2, 8'h01);
    exec(8'h01, 3, 1, 2, e);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 8'h01; instr_rd = 3'd4; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_flags", 32'(flags_q), 32'd0);
    check("abort_sel", 32'(alu_sel), 32'd0);
    for (int i = 0; i < 8; i++) mr[i] = 8'h00;
    mflags = 7'h00;
    check_all_regs("abort_regs");
    @(negedge clk) rst = 1'b0;
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    exec(8'h05, 1, 0, 0, e);
    check_all_regs("post_abort_regs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
